// File: rtl/am_pkg.sv
// Shared types and helpers for the AM envelope demodulator: FSM encoding,
// sample/index widths, offset-binary conversion and 12-bit saturation.
package am_pkg;

  localparam int SAMP_W = 12;
  localparam int INDX_W = 8;

  typedef enum logic [1:0] {
    S_ACC,
    S_DIV,
    S_OUT
  } state_t;

  // Offset binary (0x800 = zero) to two's complement: flip the MSB.
  function automatic logic signed [SAMP_W-1:0] ob_to_signed(input logic [SAMP_W-1:0] x);
    return {~x[SAMP_W-1], x[SAMP_W-2:0]};
  endfunction

  function automatic logic [SAMP_W-1:0] sat12(input logic signed [SAMP_W:0] x);
    if (x > 13'sd2047) begin
      return 12'h7FF;
    end else if (x < -13'sd2048) begin
      return 12'h800;
    end else begin
      return x[SAMP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/div_restoring.sv
// Restoring divider, 20-bit / 12-bit -> 9-bit quotient, one quotient bit per clk.
// The caller guarantees num < den*512, so only the top 9 alignment steps are needed.
module div_restoring (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] num,
  input  logic [11:0] den,
  output logic        busy,
  output logic        done,
  output logic [8:0]  quo
);

  logic [19:0] rem;
  logic [19:0] dsh;
  logic [3:0]  it;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      quo  <= '0;
      rem  <= '0;
      dsh  <= '0;
      it   <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem  <= num;
        dsh  <= {den, 8'h00};
        quo  <= '0;
        it   <= 4'd8;
        busy <= 1'b1;
      end else if (busy) begin
        if (rem >= dsh) begin
          rem <= rem - dsh;
          quo <= {quo[7:0], 1'b1};
        end else begin
          quo <= {quo[7:0], 1'b0};
        end
        dsh <= dsh >> 1;
        if (it == 4'd0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          it <= it - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/am_env_demod.sv
// AM envelope demodulator: rectify, peak-track with exponential decay, remove
// the carrier DC, and measure the modulation index once per window.
module am_env_demod
  import am_pkg::*;
#(
  parameter int WIN_LEN  = 1024,
  parameter int DECAY_SH = 6,
  parameter int DC_SH    = 10,
  parameter int FRAC     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pls,
  input  logic [SAMP_W-1:0] mod_in,
  output logic [SAMP_W-1:0] env_out,
  output logic              env_vld,
  output logic [INDX_W-1:0] indx_meas,
  output logic              meas_vld
);

  localparam int ENV_W = 11 + FRAC;
  localparam int CNT_W = $clog2(WIN_LEN);

  logic              run;
  logic              en2, en3, en4;
  logic [10:0]       a;
  logic [ENV_W-1:0]  env, dc;
  logic [CNT_W-1:0]  cnt;
  logic [10:0]       wmax, wmin;
  logic              close;
  logic [19:0]       num;
  logic [11:0]       den;
  state_t            state;
  logic              div_start, div_busy, div_done;
  logic [8:0]        div_q, q;

  // Stage 1: rectify; |-2048| does not fit 11 bits and clamps to 2047.
  logic [SAMP_W-1:0] s, mag;
  logic [10:0]       a_next;
  assign s      = ob_to_signed(mod_in);
  assign mag    = s[SAMP_W-1] ? (~s + 12'd1) : s;
  assign a_next = mag[11] ? 11'h7FF : mag[10:0];

  // Stage 2: instant attack, exponential decay.
  logic [10:0]      env_int, env_next_int, dc_int;
  logic [ENV_W-1:0] env_next;
  assign env_int      = env[ENV_W-1:FRAC];
  assign env_next     = (a > env_int) ? {a, {FRAC{1'b0}}} : env - (env >> DECAY_SH);
  assign env_next_int = env_next[ENV_W-1:FRAC];
  assign dc_int       = dc[ENV_W-1:FRAC];

  logic        first, last;
  logic [10:0] wmax_n, wmin_n;
  assign first  = (cnt == '0);
  assign last   = (cnt == CNT_W'(WIN_LEN - 1));
  assign wmax_n = (first || env_next_int > wmax) ? env_next_int : wmax;
  assign wmin_n = (first || env_next_int < wmin) ? env_next_int : wmin;

  // Stage 3: slow DC tracker; the truncated add wraps correctly for negative steps.
  logic signed [ENV_W:0] dc_diff, dc_step;
  logic signed [SAMP_W:0] out_diff;
  assign dc_diff  = $signed({1'b0, env}) - $signed({1'b0, dc});
  assign dc_step  = dc_diff >>> DC_SH;
  assign out_diff = $signed({2'b00, env_int}) - $signed({2'b00, dc_int});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run     <= 1'b0;
      en2     <= 1'b0;
      en3     <= 1'b0;
      en4     <= 1'b0;
      a       <= '0;
      env     <= '0;
      dc      <= '0;
      env_out <= '0;
      env_vld <= 1'b0;
      cnt     <= '0;
      wmax    <= '0;
      wmin    <= '0;
      close   <= 1'b0;
      num     <= '0;
      den     <= '0;
    end else begin
      // A strobe on the first clk after reset release is dropped.
      run     <= 1'b1;
      en2     <= pls & run;
      en3     <= en2;
      en4     <= en3;
      env_vld <= en4;
      close   <= 1'b0;
      if (pls && run) a <= a_next;
      if (en2) begin
        env  <= env_next;
        wmax <= wmax_n;
        wmin <= wmin_n;
        cnt  <= last ? '0 : cnt + CNT_W'(1);
        if (last) begin
          close <= 1'b1;
          num   <= {1'b0, wmax_n - wmin_n, 8'h00};
          den   <= {1'b0, wmax_n} + {1'b0, wmin_n};
        end
      end
      if (en3) dc <= dc + dc_step[ENV_W-1:0];
      if (en4) env_out <= sat12(out_diff);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_ACC;
      div_start <= 1'b0;
      q         <= '0;
      indx_meas <= '0;
      meas_vld  <= 1'b0;
    end else begin
      div_start <= 1'b0;
      meas_vld  <= 1'b0;
      case (state)
        S_ACC: if (close) begin
          state     <= S_DIV;
          div_start <= (den != 12'd0) && !div_busy;
        end
        S_DIV: if (den == 12'd0) begin
          q     <= '0;
          state <= S_OUT;
        end else if (div_done) begin
          q     <= div_q;
          state <= S_OUT;
        end
        S_OUT: begin
          indx_meas <= (q > 9'd255) ? 8'hFF : q[7:0];
          meas_vld  <= 1'b1;
          state     <= S_ACC;
        end
        default: state <= S_ACC;
      endcase
    end
  end

  div_restoring u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (num),
    .den   (den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_q)
  );

endmodule

// File: tb/tb_am_env_demod.sv
// Directed bench for am_env_demod with a short window and fast DC tracker so
// every expected value can be worked out by hand.
module tb_am_env_demod;

  localparam int WIN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pls = 1'b0;
  logic [11:0] mod_in = 12'h800;
  logic [11:0] env_out;
  logic        env_vld;
  logic [7:0]  indx_meas;
  logic        meas_vld;

  int checks = 0;
  int passed = 0;
  int meas_cnt = 0, wide_cnt = 0, nz_cnt = 0;
  logic prev_meas = 1'b0;
  logic [11:0] last_env;
  logic        last_vld;

  always #4 clk = ~clk;

  am_env_demod #(.WIN_LEN(WIN), .DECAY_SH(6), .DC_SH(2), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .pls(pls), .mod_in(mod_in),
    .env_out(env_out), .env_vld(env_vld),
    .indx_meas(indx_meas), .meas_vld(meas_vld)
  );

  always @(negedge clk) begin
    if (meas_vld) meas_cnt++;
    if (meas_vld && prev_meas) wide_cnt++;
    prev_meas = meas_vld;
    if (env_vld && env_out != 12'd0) nz_cnt++;
  end

  function automatic logic [11:0] ob(input int v);
    return 12'(2048 + v);
  endfunction

  task automatic do_reset;
    rst = 1'b0; pls = 1'b0; mod_in = 12'h800;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One strobe; captures env_out/env_vld at the expected latency point.
  task automatic send(input logic [11:0] x, input int gap);
    @(negedge clk); mod_in = x; pls = 1'b1;
    @(negedge clk); pls = 1'b0;
    repeat (3) @(negedge clk);
    last_env = env_out; last_vld = env_vld;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    logic seen;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); mod_in = 12'($urandom); pls = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    checks++; if (env_out !== 12'd0) $display("FAIL rst_env_out: got %h want 000", env_out); else passed++;
    checks++; if (env_vld !== 1'b0) $display("FAIL rst_env_vld: got %b want 0", env_vld); else passed++;
    checks++; if (indx_meas !== 8'd0) $display("FAIL rst_indx: got %0d want 0", indx_meas); else passed++;
    checks++; if (meas_vld !== 1'b0) $display("FAIL rst_meas_vld: got %b want 0", meas_vld); else passed++;
    // Strobe present on the release cycle must be dropped.
    mod_in = 12'h864; pls = 1'b1; rst = 1'b1;
    @(negedge clk); pls = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= env_vld; end
    checks++; if (seen !== 1'b0) $display("FAIL rel_pls_ignored: got env_vld %b want 0", seen); else passed++;
    checks++; if (env_out !== 12'd0) $display("FAIL rel_env_out: got %h want 000", env_out); else passed++;
  endtask

  task automatic test_latency;
    logic [3:0] v;
    logic [11:0] e3;
    do_reset();
    @(negedge clk); mod_in = 12'h864; pls = 1'b1;
    @(negedge clk); pls = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); v[k-1] = env_vld;
      if (k == 3) e3 = env_out;
    end
    checks++; if (v[1:0] !== 2'b00) $display("FAIL lat_early: got %b want 00", v[1:0]); else passed++;
    checks++; if (v[2] !== 1'b1) $display("FAIL lat_vld3: got %b want 1", v[2]); else passed++;
    checks++; if (v[3] !== 1'b0) $display("FAIL lat_width: got %b want 0", v[3]); else passed++;
    // env=100, dc=25600>>2 -> 25
    checks++; if (e3 !== 12'd75) $display("FAIL lat_env1: got %0d want 75", e3); else passed++;
    repeat (12) @(negedge clk);
    send(12'h864, 16);   // decay to 98, dc 43
    checks++; if (last_env !== 12'd55) $display("FAIL env_decay: got %0d want 55", last_env); else passed++;
    send(12'h79C, 16);   // -100 rectified: re-attack to 100, dc 57
    checks++; if (last_env !== 12'd43) $display("FAIL env_neg: got %0d want 43", last_env); else passed++;
  endtask

  task automatic test_zero;
    int mb, wb, nb;
    do_reset();
    mb = meas_cnt; wb = wide_cnt; nb = nz_cnt;
    repeat (WIN - 1) send(12'h800, 16);
    checks++; if (meas_cnt !== mb) $display("FAIL zero_early_meas: got %0d want %0d", meas_cnt, mb); else passed++;
    send(12'h800, 16);
    checks++; if (meas_cnt !== mb + 1) $display("FAIL zero_meas1: got %0d want %0d", meas_cnt, mb + 1); else passed++;
    checks++; if (indx_meas !== 8'd0) $display("FAIL zero_indx: got %0d want 0", indx_meas); else passed++;
    repeat (WIN) send(12'h800, 16);
    checks++; if (meas_cnt !== mb + 2) $display("FAIL zero_meas2: got %0d want %0d", meas_cnt, mb + 2); else passed++;
    checks++; if (wide_cnt !== wb || nz_cnt !== nb)
      $display("FAIL zero_width_env: got wide %0d nz %0d want %0d %0d", wide_cnt, nz_cnt, wb, nb); else passed++;
  endtask

  task automatic test_full_scale;
    int mb;
    do_reset();
    mb = meas_cnt;
    send(12'h000, 16);   // env 2047, dc int 511
    checks++; if (last_env !== 12'd1536) $display("FAIL fs_env1: got %0d want 1536", last_env); else passed++;
    send(12'h000, 16);   // env 2015, dc int 887
    checks++; if (last_env !== 12'd1128) $display("FAIL fs_env2: got %0d want 1128", last_env); else passed++;
    repeat (WIN - 2) send(12'h000, 16);
    // window 2015..2047: 8192/4062 -> 2
    checks++; if (meas_cnt !== mb + 1) $display("FAIL fs_meas: got %0d want %0d", meas_cnt, mb + 1); else passed++;
    checks++; if (indx_meas !== 8'd2) $display("FAIL fs_indx: got %0d want 2", indx_meas); else passed++;
  endtask

  task automatic test_modulated;
    int mb, amp;
    do_reset();
    mb = meas_cnt;
    // Rising envelope 500..1500, alternating sign: 256000/2000 -> 128
    for (int i = 0; i < WIN; i++) begin
      amp = (i == WIN - 1) ? 1500 : 500 + 60 * i;
      send(ob((i % 2) ? -amp : amp), 16);
    end
    checks++; if (meas_cnt !== mb + 1) $display("FAIL mod_meas1: got %0d want %0d", meas_cnt, mb + 1); else passed++;
    checks++; if (indx_meas !== 8'd128) $display("FAIL mod_indx1: got %0d want 128", indx_meas); else passed++;
    // Back-to-back window 1600..1750: 38400/3350 -> 11
    for (int i = 0; i < WIN; i++) begin
      amp = 1600 + 10 * i;
      send(ob((i % 2) ? -amp : amp), 16);
    end
    checks++; if (meas_cnt !== mb + 2) $display("FAIL mod_meas2: got %0d want %0d", meas_cnt, mb + 2); else passed++;
    checks++; if (indx_meas !== 8'd11) $display("FAIL mod_indx2: got %0d want 11", indx_meas); else passed++;
  endtask

  task automatic test_sat;
    do_reset();
    send(12'h800, 16);
    repeat (WIN - 1) send(ob(1000), 16);
    // min 0, max 1000: quotient 256 clamps
    checks++; if (indx_meas !== 8'd255) $display("FAIL sat_indx: got %0d want 255", indx_meas); else passed++;
  endtask

  task automatic test_reset_in_div;
    int mb, amp;
    do_reset();
    mb = meas_cnt;
    for (int i = 0; i < WIN; i++) begin
      amp = (i == WIN - 1) ? 1500 : 500 + 60 * i;
      send(ob(amp), (i == WIN - 1) ? 3 : 16);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (meas_cnt !== mb) $display("FAIL rdiv_no_meas: got %0d want %0d", meas_cnt, mb); else passed++;
    checks++; if (indx_meas !== 8'd0) $display("FAIL rdiv_indx: got %0d want 0", indx_meas); else passed++;
    for (int i = 0; i < WIN - 1; i++) send(ob(500 + 60 * i), 16);
    checks++; if (meas_cnt !== mb) $display("FAIL rdiv_early: got %0d want %0d", meas_cnt, mb); else passed++;
    send(ob(1500), 16);
    checks++; if (meas_cnt !== mb + 1 || indx_meas !== 8'd128)
      $display("FAIL rdiv_next: got cnt %0d indx %0d want %0d 128", meas_cnt, indx_meas, mb + 1); else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_zero();
    test_full_scale();
    test_modulated();
    test_sat();
    test_reset_in_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
